// File: rtl/life_window_if.sv
// ---------------------------------------------------------------------------
// life_window_if
// Groups the handshake and data signals of life_window_gen.
//   in_valid/in_ready/in_cell : serial raster-order board input
//   out_valid/out_ready       : window handshake
//   out_self                  : state of the current cell
//   out_nbr[7:0]              : neighbour bits, NW,N,NE,W,E,SW,S,SE
//   out_count[3:0]            : number of live neighbours
//   out_last                  : window of the bottom-right cell
// Modports: master = producer/consumer side (testbench), slave = generator.
// ---------------------------------------------------------------------------
interface life_window_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_cell;
  logic       out_valid;
  logic       out_ready;
  logic       out_self;
  logic [7:0] out_nbr;
  logic [3:0] out_count;
  logic       out_last;

  modport master (
    output in_valid, in_cell, out_ready,
    input  in_ready, out_valid, out_self, out_nbr, out_count, out_last
  );

  modport slave (
    input  in_valid, in_cell, out_ready,
    output in_ready, out_valid, out_self, out_nbr, out_count, out_last
  );
endinterface

// File: rtl/life_window_gen.sv
// ---------------------------------------------------------------------------
// life_window_gen
// Frame-buffered Game-of-Life neighbourhood generator. A whole board is
// loaded as a raster-order bit stream, then one window (cell, its eight
// neighbours and their live count) is emitted per output handshake.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : life_window_if.slave (input stream + window output handshake)
// Parameters:
//   WIDTH, HEIGHT : board size (>= 3 each)
//   TORUS         : 0 = off-board neighbours read dead, 1 = indices wrap
// ---------------------------------------------------------------------------
module life_window_gen #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int TORUS  = 0
) (
  input  logic          clk,
  input  logic          rst,
  life_window_if.slave  bus
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IW    = (CELLS  > 1) ? $clog2(CELLS)  : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {
    S_LOAD,
    S_EMIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RW-1:0]    r_row;
  logic [RW-1:0]    w_row_nxt;
  logic [CW-1:0]    r_col;
  logic [CW-1:0]    w_col_nxt;
  logic [CELLS-1:0] r_frame;

  logic             w_take;
  logic             w_give;
  logic             w_adv;
  logic             w_at_last;
  logic [IW-1:0]    w_wr_idx;
  logic [7:0]       w_nbr;
  logic [3:0]       w_count;
  int               w_ri;
  int               w_ci;

  // Reads one board cell; out-of-range coordinates (at most one step off
  // the board) either wrap or read as dead depending on TORUS.
  function automatic logic cell_at(input logic [CELLS-1:0] frame,
                                   input int rr, input int cc);
    int r2 = rr;
    int c2 = cc;
    if (TORUS == 0) begin
      if (r2 < 0 || r2 >= HEIGHT || c2 < 0 || c2 >= WIDTH) return 1'b0;
    end else begin
      if (r2 < 0)            r2 = HEIGHT - 1;
      else if (r2 >= HEIGHT) r2 = 0;
      if (c2 < 0)            c2 = WIDTH - 1;
      else if (c2 >= WIDTH)  c2 = 0;
    end
    return frame[IW'(r2 * WIDTH + c2)];
  endfunction

  assign w_at_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_wr_idx  = IW'(int'(r_row) * WIDTH + int'(r_col));

  // Control: handshakes, shared raster counter and next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    // Reset forces both handshakes low combinationally.
    if (!rst) begin
      case (r_state)
        S_LOAD:  bus.in_ready  = 1'b1;
        S_EMIT:  bus.out_valid = 1'b1;
        default: ;
      endcase
    end

    w_take = bus.in_valid  & bus.in_ready;
    w_give = bus.out_valid & bus.out_ready;
    // LOAD and EMIT walk the board in the same raster order, so one
    // counter pair serves both phases.
    w_adv  = w_take | w_give;

    if (w_adv) begin
      if (r_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
      if (w_at_last) w_state_nxt = (r_state == S_LOAD) ? S_EMIT : S_LOAD;
    end
  end

  // Window datapath: purely combinational from the buffer and counters so
  // the window is valid in the same cycle the counters point at a cell.
  always_comb begin
    w_ri     = int'(r_row);
    w_ci     = int'(r_col);
    w_nbr[0] = cell_at(r_frame, w_ri - 1, w_ci - 1);
    w_nbr[1] = cell_at(r_frame, w_ri - 1, w_ci    );
    w_nbr[2] = cell_at(r_frame, w_ri - 1, w_ci + 1);
    w_nbr[3] = cell_at(r_frame, w_ri,     w_ci - 1);
    w_nbr[4] = cell_at(r_frame, w_ri,     w_ci + 1);
    w_nbr[5] = cell_at(r_frame, w_ri + 1, w_ci - 1);
    w_nbr[6] = cell_at(r_frame, w_ri + 1, w_ci    );
    w_nbr[7] = cell_at(r_frame, w_ri + 1, w_ci + 1);
    w_count  = '0;
    for (int b = 0; b < 8; b++) w_count = w_count + 4'(w_nbr[b]);
  end

  assign bus.out_self  = cell_at(r_frame, w_ri, w_ci);
  assign bus.out_nbr   = w_nbr;
  assign bus.out_count = w_count;
  assign bus.out_last  = w_at_last;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_LOAD;
      r_row   <= '0;
      r_col   <= '0;
      // NOTE: the frame buffer is flop-based and small, so it is cleared on
      // reset; a RAM-backed buffer would not be reset like this.
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      if (w_take) r_frame[w_wr_idx] <= bus.in_cell;
    end
  end

endmodule

// File: tb/tb_life_window_gen.sv
// ---------------------------------------------------------------------------
// tb_life_window_gen
// Directed bench for life_window_gen. Two instances (TORUS=0 and TORUS=1)
// on an 8x8 board receive identical stimulus; windows are captured per
// handshake and compared against hand-computed values and a reference
// neighbourhood model.
// ---------------------------------------------------------------------------
module tb_life_window_gen;

  localparam int DR [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
  localparam int DC [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  life_window_if b0 ();
  life_window_if b1 ();

  life_window_gen #(.WIDTH(8), .HEIGHT(8), .TORUS(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  life_window_gen #(.WIDTH(8), .HEIGHT(8), .TORUS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cap_nbr0  [64];
  logic [7:0] cap_nbr1  [64];
  logic [3:0] cap_cnt0  [64];
  logic [3:0] cap_cnt1  [64];
  logic       cap_self0 [64];
  logic       cap_self1 [64];
  logic       cap_last0 [64];
  logic       cap_last1 [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic r);
    b0.in_valid  = v;  b1.in_valid  = v;
    b0.in_cell   = c;  b1.in_cell   = c;
    b0.out_ready = r;  b1.out_ready = r;
  endtask

  function automatic logic [7:0] model_nbr(input logic [63:0] f, input int r,
                                           input int c, input bit tor);
    logic [7:0] res = '0;
    for (int k = 0; k < 8; k++) begin
      int rr = r + DR[k];
      int cc = c + DC[k];
      if (tor) begin
        rr = (rr + 8) % 8;
        cc = (cc + 8) % 8;
        res[k] = f[6'(rr * 8 + cc)];
      end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
        res[k] = f[6'(rr * 8 + cc)];
      end
    end
    return res;
  endfunction

  // Stream a frame in; out_ready is held high to show it has no effect.
  task automatic load_frame(input logic [63:0] f, input string tag);
    bit timed_out = 0;
    for (int k = 0; k < 64; k++) begin
      int w = 0;
      drive(1'b1, f[k], 1'b1);
      while (b0.in_ready !== 1'b1 && w < 200) begin
        @(posedge clk); #1; w++;
      end
      if (w >= 200) timed_out = 1;
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0);
    check({tag, "_load_timeout"}, 32'(timed_out), 0);
    check({tag, "_emit_after_load"}, 32'(b0.out_valid & b1.out_valid), 1);
  endtask

  // Collect n_win windows. in_valid is held high throughout to show it is
  // ignored in EMIT; rnd toggles out_ready at 50%.
  task automatic emit(input int n_win, input bit rnd, input string tag);
    int   n_hs = 0;
    int   cyc  = 0;
    bit   have_prev = 0;
    bit   stall_ok = 1, iready_ok = 1, sync_ok = 1;
    logic p_self, p_last;
    logic [7:0] p_nbr0, p_nbr1;
    logic [3:0] p_cnt0;
    logic rdy;
    while (n_hs < n_win && cyc < 2000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(1'b1, 1'b1, rdy);
      if (b0.in_ready !== 1'b0 || b1.in_ready !== 1'b0) iready_ok = 0;
      if (b0.out_valid !== b1.out_valid) sync_ok = 0;
      if (have_prev) begin
        if (b0.out_self !== p_self || b0.out_nbr !== p_nbr0 ||
            b0.out_count !== p_cnt0 || b0.out_last !== p_last ||
            b1.out_nbr !== p_nbr1) stall_ok = 0;
      end
      if (b0.out_valid === 1'b1 && rdy) begin
        cap_self0[n_hs] = b0.out_self;  cap_self1[n_hs] = b1.out_self;
        cap_nbr0[n_hs]  = b0.out_nbr;   cap_nbr1[n_hs]  = b1.out_nbr;
        cap_cnt0[n_hs]  = b0.out_count; cap_cnt1[n_hs]  = b1.out_count;
        cap_last0[n_hs] = b0.out_last;  cap_last1[n_hs] = b1.out_last;
        n_hs++;
        have_prev = 0;
      end else if (b0.out_valid === 1'b1) begin
        have_prev = 1;
        p_self = b0.out_self;  p_nbr0 = b0.out_nbr;  p_cnt0 = b0.out_count;
        p_last = b0.out_last;  p_nbr1 = b1.out_nbr;
      end else begin
        have_prev = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0);
    check({tag, "_handshakes"}, 32'(n_hs), 32'(n_win));
    check({tag, "_in_ready_low"}, 32'(iready_ok), 1);
    check({tag, "_valid_sync"}, 32'(sync_ok), 1);
    if (rnd) check({tag, "_stall_stable"}, 32'(stall_ok), 1);
  endtask

  // Compare all 64 captured windows of both instances with the model.
  task automatic verify(input logic [63:0] f, input string tag);
    int bad0 = 0, bad1 = 0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e0 = model_nbr(f, i / 8, i % 8, 1'b0);
      logic [7:0] e1 = model_nbr(f, i / 8, i % 8, 1'b1);
      logic es = f[6'(i)];
      logic el = (i == 63);
      if (cap_nbr0[i] !== e0 || cap_cnt0[i] !== 4'($countones(e0)) ||
          cap_self0[i] !== es || cap_last0[i] !== el) bad0++;
      if (cap_nbr1[i] !== e1 || cap_cnt1[i] !== 4'($countones(e1)) ||
          cap_self1[i] !== es || cap_last1[i] !== el) bad1++;
    end
    check({tag, "_model_T0_bad_windows"}, 32'(bad0), 0);
    check({tag, "_model_T1_bad_windows"}, 32'(bad1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f_blink, f_single, f_full, f_rand;
    logic [7:0]  tmp;
    bit          ok;
    int          n_last;

    f_blink  = '0; f_blink[26] = 1'b1; f_blink[27] = 1'b1; f_blink[28] = 1'b1;
    f_single = '0; f_single[0] = 1'b1;
    f_full   = '1;
    f_rand   = 64'hA5C3_1F0E_7B29_D468;

    // Reset / idle
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    ok = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b0 ||
          b1.in_ready !== 1'b0 || b1.out_valid !== 1'b0) ok = 0;
    end
    check("reset_handshakes_low", 32'(ok), 1);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(b0.in_ready), 1);
    check("post_reset_out_valid", 32'(b0.out_valid), 0);
    ok = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) ok = 0;
    end
    check("idle_10_cycles", 32'(ok), 1);

    // Blinker
    load_frame(f_blink, "blink");
    emit(64, 1'b0, "blink");
    check("blink_turnaround_in_ready", 32'(b0.in_ready), 1);
    check("blink_33_self", 32'(cap_self0[27]), 1);
    check("blink_33_nbr", 32'(cap_nbr0[27]), 32'h18);
    check("blink_33_count", 32'(cap_cnt0[27]), 2);
    check("blink_23_self", 32'(cap_self0[19]), 0);
    check("blink_23_count", 32'(cap_cnt0[19]), 3);
    check("blink_00_count", 32'(cap_cnt0[0]), 0);
    n_last = 0;
    for (int i = 0; i < 64; i++) n_last += int'(cap_last0[i]);
    check("blink_last_once", 32'(n_last), 1);
    check("blink_last_on_64th", 32'(cap_last0[63]), 1);
    verify(f_blink, "blink");

    // Single live cell at (0,0): edge vs torus
    load_frame(f_single, "single");
    emit(64, 1'b0, "single");
    check("single_T0_77_count", 32'(cap_cnt0[63]), 0);
    check("single_T1_77_nbr", 32'(cap_nbr1[63]), 32'h80);
    check("single_T1_77_count", 32'(cap_cnt1[63]), 1);
    tmp = cap_nbr1[7];
    check("single_T1_07_nbr4", 32'(tmp[4]), 1);
    verify(f_single, "single");

    // Backpressure with a mixed pattern
    load_frame(f_rand, "bp");
    emit(64, 1'b1, "bp");
    check("bp_turnaround_in_ready", 32'(b0.in_ready), 1);
    verify(f_rand, "bp");

    // Full board
    load_frame(f_full, "full");
    emit(64, 1'b0, "full");
    check("full_interior_count", 32'(cap_cnt0[27]), 8);
    check("full_edge_count", 32'(cap_cnt0[3]), 5);
    check("full_corner00_count", 32'(cap_cnt0[0]), 3);
    check("full_corner77_count", 32'(cap_cnt0[63]), 3);
    check("full_T1_corner_count", 32'(cap_cnt1[0]), 8);
    verify(f_full, "full");

    // Reset after window 20 of EMIT
    load_frame(f_blink, "midrst");
    emit(20, 1'b0, "midrst");
    rst = 1'b1;
    #1;
    check("midrst_in_ready_during", 32'(b0.in_ready), 0);
    check("midrst_out_valid_during", 32'(b0.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready_after", 32'(b0.in_ready), 1);
    check("midrst_out_valid_after", 32'(b0.out_valid), 0);

    // Back-to-back frames, no idle gap
    load_frame(f_full, "b2b_a");
    emit(64, 1'b0, "b2b_a");
    verify(f_full, "b2b_a");
    load_frame(f_single, "b2b_b");
    emit(64, 1'b0, "b2b_b");
    check("b2b_b_33_count", 32'(cap_cnt0[27]), 0);
    check("b2b_b_33_self", 32'(cap_self0[27]), 0);
    verify(f_single, "b2b_b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
